// File: rtl/hpdcache_flush_sweep.sv
// Full-cache flush sequencer: walks every directory set, hands each valid
// dirty line to the flush controller, cleans (or invalidates) the directory
// entries, then waits for the flush controller to drain before completing.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a sweep request
// READ  | directory read strobe for set_q
// SCAN  | capture valid/dirty/tags returned by the directory
// ALLOC | one flush allocation per pending dirty way, lowest way first
// INVAL | invalidate the clean valid ways of set_q (invalidate mode)
// DRAIN | all sets visited, waiting for outstanding write-backs
// DONE  | one-cycle completion pulse
module hpdcache_flush_sweep #(
    parameter int unsigned SETS      = 64,
    parameter int unsigned WAYS      = 8,
    parameter int unsigned TAG_WIDTH = 20,
    localparam int unsigned SetWidth   = $clog2(SETS),
    localparam int unsigned NlineWidth = TAG_WIDTH + SetWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      sweep_req_i,
    input  logic                      sweep_inval_i,
    output logic                      sweep_busy_o,
    output logic                      sweep_done_o,
    output logic                      dir_read_o,
    output logic [SetWidth-1:0]       dir_read_set_o,
    input  logic [WAYS-1:0]           dir_valid_i,
    input  logic [WAYS-1:0]           dir_dirty_i,
    input  logic [WAYS*TAG_WIDTH-1:0] dir_tag_i,
    output logic                      dir_upd_o,
    output logic [SetWidth-1:0]       dir_upd_set_o,
    output logic [WAYS-1:0]           dir_upd_way_o,
    output logic                      dir_upd_inval_o,
    output logic                      flush_alloc_o,
    input  logic                      flush_alloc_ready_i,
    output logic [NlineWidth-1:0]     flush_alloc_nline_o,
    output logic [WAYS-1:0]           flush_alloc_way_o,
    output logic                      flush_alloc_inval_o,
    input  logic                      flush_empty_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SCAN,
        S_ALLOC,
        S_INVAL,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [SetWidth-1:0]        set_q, set_d;
    logic                       inval_q, inval_d;
    logic [WAYS-1:0]            pend_q, pend_d;
    logic [WAYS-1:0]            clean_q, clean_d;
    logic [WAYS*TAG_WIDTH-1:0]  tag_q, tag_d;

    logic [WAYS-1:0]            sel_oh;
    logic [TAG_WIDTH-1:0]       sel_tag;
    logic                       last_set;

    // Lowest pending way as a one-hot vector, and its captured tag.
    always_comb begin
        sel_oh  = pend_q & (~pend_q + WAYS'(1));
        sel_tag = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (sel_oh[w]) begin
                sel_tag = tag_q[w*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    // The set counter never wraps; the last set is detected by equality.
    assign last_set     = (set_q == SetWidth'(SETS - 1));
    assign sweep_busy_o = (state_q != S_IDLE);

    // Next-state and output decode; every output idles at zero.
    always_comb begin
        state_d             = state_q;
        set_d               = set_q;
        inval_d             = inval_q;
        pend_d              = pend_q;
        clean_d             = clean_q;
        tag_d               = tag_q;
        sweep_done_o        = 1'b0;
        dir_read_o          = 1'b0;
        dir_read_set_o      = '0;
        dir_upd_o           = 1'b0;
        dir_upd_set_o       = '0;
        dir_upd_way_o       = '0;
        dir_upd_inval_o     = 1'b0;
        flush_alloc_o       = 1'b0;
        flush_alloc_nline_o = '0;
        flush_alloc_way_o   = '0;
        flush_alloc_inval_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sweep_req_i) begin
                    inval_d = sweep_inval_i;
                    set_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                dir_read_o     = 1'b1;
                dir_read_set_o = set_q;
                state_d        = S_SCAN;
            end
            S_SCAN: begin
                pend_d  = dir_valid_i & dir_dirty_i;
                clean_d = dir_valid_i & ~dir_dirty_i;
                tag_d   = dir_tag_i;
                state_d = S_ALLOC;
            end
            S_ALLOC: begin
                if (pend_q != '0) begin
                    flush_alloc_o       = 1'b1;
                    flush_alloc_nline_o = {sel_tag, set_q};
                    flush_alloc_way_o   = sel_oh;
                    flush_alloc_inval_o = inval_q;
                    if (flush_alloc_ready_i) begin
                        pend_d          = pend_q & ~sel_oh;
                        dir_upd_o       = 1'b1;
                        dir_upd_set_o   = set_q;
                        dir_upd_way_o   = sel_oh;
                        dir_upd_inval_o = inval_q;
                    end
                end else if (inval_q && (clean_q != '0)) begin
                    state_d = S_INVAL;
                end else if (last_set) begin
                    state_d = S_DRAIN;
                end else begin
                    set_d   = set_q + SetWidth'(1);
                    state_d = S_READ;
                end
            end
            S_INVAL: begin
                dir_upd_o       = 1'b1;
                dir_upd_set_o   = set_q;
                dir_upd_way_o   = clean_q;
                dir_upd_inval_o = 1'b1;
                if (last_set) begin
                    state_d = S_DRAIN;
                end else begin
                    set_d   = set_q + SetWidth'(1);
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (flush_empty_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                sweep_done_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and sweep-context registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            set_q   <= '0;
            inval_q <= 1'b0;
            pend_q  <= '0;
            clean_q <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            inval_q <= inval_d;
            pend_q  <= pend_d;
            clean_q <= clean_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_hpdcache_flush_sweep.sv
// Bench for hpdcache_flush_sweep: a directory memory model answers reads and
// absorbs updates; expected allocations, updates and completion time are
// derived from the directory contents before each sweep.
module tb_hpdcache_flush_sweep;

    localparam int SETS = 4;
    localparam int WAYS = 8;
    localparam int TW   = 20;
    localparam int SW   = 2;
    localparam int NW   = TW + SW;

    logic              clk;
    logic              rst_ni;
    logic              sweep_req_i, sweep_inval_i;
    logic              sweep_busy_o, sweep_done_o;
    logic              dir_read_o;
    logic [SW-1:0]     dir_read_set_o;
    logic [WAYS-1:0]   dir_valid_i, dir_dirty_i;
    logic [WAYS*TW-1:0] dir_tag_i;
    logic              dir_upd_o;
    logic [SW-1:0]     dir_upd_set_o;
    logic [WAYS-1:0]   dir_upd_way_o;
    logic              dir_upd_inval_o;
    logic              flush_alloc_o, flush_alloc_ready_i;
    logic [NW-1:0]     flush_alloc_nline_o;
    logic [WAYS-1:0]   flush_alloc_way_o;
    logic              flush_alloc_inval_o;
    logic              flush_empty_i;

    hpdcache_flush_sweep #(.SETS(SETS), .WAYS(WAYS), .TAG_WIDTH(TW)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .sweep_req_i         (sweep_req_i),
        .sweep_inval_i       (sweep_inval_i),
        .sweep_busy_o        (sweep_busy_o),
        .sweep_done_o        (sweep_done_o),
        .dir_read_o          (dir_read_o),
        .dir_read_set_o      (dir_read_set_o),
        .dir_valid_i         (dir_valid_i),
        .dir_dirty_i         (dir_dirty_i),
        .dir_tag_i           (dir_tag_i),
        .dir_upd_o           (dir_upd_o),
        .dir_upd_set_o       (dir_upd_set_o),
        .dir_upd_way_o       (dir_upd_way_o),
        .dir_upd_inval_o     (dir_upd_inval_o),
        .flush_alloc_o       (flush_alloc_o),
        .flush_alloc_ready_i (flush_alloc_ready_i),
        .flush_alloc_nline_o (flush_alloc_nline_o),
        .flush_alloc_way_o   (flush_alloc_way_o),
        .flush_alloc_inval_o (flush_alloc_inval_o),
        .flush_empty_i       (flush_empty_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NW-1:0]   nline;
        logic [WAYS-1:0] way;
        logic            inv;
    } alloc_t;

    typedef struct packed {
        logic [SW-1:0]   set;
        logic [WAYS-1:0] way;
        logic            inv;
    } upd_t;

    int passed = 0;
    int total  = 0;

    logic [WAYS-1:0] mv [SETS];
    logic [WAYS-1:0] md [SETS];
    logic [TW-1:0]   mt [SETS][WAYS];

    logic            rd_pend;
    logic [SW-1:0]   rd_set;

    alloc_t          obs_alloc[$], exp_alloc[$];
    upd_t            obs_upd[$], exp_upd[$];
    logic [SW-1:0]   obs_rd[$];
    bit              empty_hist[$];
    bit              busy_hist[$];

    function automatic logic [63:0] all_outs();
        return {15'd0, sweep_busy_o, sweep_done_o, dir_read_o, dir_read_set_o,
                dir_upd_o, dir_upd_set_o, dir_upd_way_o, dir_upd_inval_o,
                flush_alloc_o, flush_alloc_nline_o, flush_alloc_way_o,
                flush_alloc_inval_o};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Directory answers one cycle after a read; otherwise the bus carries junk.
    task automatic drive_dir();
        if (rd_pend) begin
            dir_valid_i = mv[rd_set];
            dir_dirty_i = md[rd_set];
            for (int w = 0; w < WAYS; w++) dir_tag_i[w*TW +: TW] = mt[rd_set][w];
        end else begin
            dir_valid_i = WAYS'($urandom);
            dir_dirty_i = WAYS'($urandom);
            dir_tag_i   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // rmode: 0 ready high, 1 random, 2 low for the first 3 alloc cycles.
    // emode: 0 empty high, 1 random, 2 low until 10 cycles into DRAIN.
    task automatic run_sweep(input bit inv, input int rmode, input int emode,
                             input bit req_noise, output int done_rel);
        logic [WAYS-1:0] v0 [SETS];
        logic [WAYS-1:0] d0 [SETS];
        logic [WAYS-1:0] clean;
        int     ndirty, ninv, nstall, first_stall, rel, drain_start, exp_done, mism;
        bit     done_seen, have_stall, rd_pend_n;
        alloc_t stalled, cur;
        upd_t   u;

        exp_alloc.delete(); exp_upd.delete(); obs_alloc.delete(); obs_upd.delete();
        obs_rd.delete(); empty_hist.delete(); busy_hist.delete();
        ndirty = 0; ninv = 0;
        for (int s = 0; s < SETS; s++) begin
            v0[s] = mv[s]; d0[s] = md[s];
            for (int w = 0; w < WAYS; w++) begin
                if (mv[s][w] && md[s][w]) begin
                    exp_alloc.push_back('{nline: {mt[s][w], SW'(s)}, way: WAYS'(1) << w, inv: inv});
                    exp_upd.push_back('{set: SW'(s), way: WAYS'(1) << w, inv: inv});
                    ndirty++;
                end
            end
            clean = mv[s] & ~md[s];
            if (inv && clean != '0) begin
                exp_upd.push_back('{set: SW'(s), way: clean, inv: 1'b1});
                ninv++;
            end
        end

        nstall = 0; first_stall = 0; have_stall = 0; done_seen = 0; rel = 0;
        done_rel = -1; stalled = '0; rd_pend = 0;
        while (!done_seen && rel < 3000) begin
            sweep_req_i   = (rel == 0) ? 1'b1 : (req_noise && $urandom_range(0, 3) == 0);
            sweep_inval_i = (rel == 0) ? inv : 1'($urandom);
            drive_dir();
            #1;
            case (rmode)
                0: flush_alloc_ready_i = 1'b1;
                1: flush_alloc_ready_i = ($urandom_range(0, 2) != 0);
                default: begin
                    flush_alloc_ready_i = !(flush_alloc_o && first_stall < 3);
                    if (flush_alloc_o && first_stall < 3) first_stall++;
                end
            endcase
            drain_start = 1 + 3*SETS + ndirty + nstall + ninv;
            case (emode)
                0: flush_empty_i = 1'b1;
                1: flush_empty_i = 1'($urandom);
                default: flush_empty_i = (rel >= drain_start + 10);
            endcase
            empty_hist.push_back(flush_empty_i);

            @(negedge clk);
            busy_hist.push_back(sweep_busy_o);
            if (sweep_done_o) begin
                done_seen = 1;
                done_rel  = rel;
            end
            rd_pend_n = dir_read_o;
            if (dir_read_o) obs_rd.push_back(dir_read_set_o);
            if (flush_alloc_o) begin
                cur = '{nline: flush_alloc_nline_o, way: flush_alloc_way_o, inv: flush_alloc_inval_o};
                if (have_stall) chk("alloc_payload_stable", cur, stalled);
                if (flush_alloc_ready_i) begin
                    obs_alloc.push_back(cur);
                    chk("upd_on_accept",
                        {dir_upd_o, dir_upd_set_o, dir_upd_way_o, dir_upd_inval_o},
                        {1'b1, flush_alloc_nline_o[SW-1:0], flush_alloc_way_o, inv});
                    have_stall = 0;
                end else begin
                    nstall++;
                    have_stall = 1;
                    stalled    = cur;
                end
            end else if (have_stall) begin
                chk("alloc_held_until_ready", flush_alloc_o, 1'b1);
                have_stall = 0;
            end
            if (dir_upd_o) begin
                u = '{set: dir_upd_set_o, way: dir_upd_way_o, inv: dir_upd_inval_o};
                obs_upd.push_back(u);
                if (u.inv) mv[u.set] = mv[u.set] & ~u.way;
                md[u.set] = md[u.set] & ~u.way;
            end
            rd_pend = rd_pend_n;
            rd_set  = obs_rd.size() > 0 ? obs_rd[$] : '0;
            @(posedge clk);
            #1;
            rel++;
        end
        sweep_req_i = 1'b0;

        drain_start = 1 + 3*SETS + ndirty + nstall + ninv;
        exp_done = -1;
        for (int i = drain_start; i < empty_hist.size(); i++) begin
            if (empty_hist[i] && exp_done < 0) exp_done = i + 1;
        end
        chk("done_seen", done_seen, 1'b1);
        chk("done_cycle", done_rel, exp_done);

        mism = 0;
        for (int i = 0; i < busy_hist.size(); i++) if (busy_hist[i] != (i >= 1)) mism++;
        chk("busy_profile_mismatches", mism, 0);

        chk("read_count", obs_rd.size(), SETS);
        mism = 0;
        for (int i = 0; i < obs_rd.size() && i < SETS; i++) if (obs_rd[i] != SW'(i)) mism++;
        chk("read_set_order", mism, 0);

        chk("alloc_count", obs_alloc.size(), exp_alloc.size());
        mism = 0;
        for (int i = 0; i < obs_alloc.size() && i < exp_alloc.size(); i++)
            if (obs_alloc[i] != exp_alloc[i]) mism++;
        chk("alloc_sequence", mism, 0);

        chk("upd_count", obs_upd.size(), exp_upd.size());
        mism = 0;
        for (int i = 0; i < obs_upd.size() && i < exp_upd.size(); i++)
            if (obs_upd[i] != exp_upd[i]) mism++;
        chk("upd_sequence", mism, 0);

        mism = 0;
        for (int s = 0; s < SETS; s++) begin
            if (md[s] != (d0[s] & ~v0[s])) mism++;
            if (mv[s] != (inv ? '0 : v0[s])) mism++;
        end
        chk("final_directory", mism, 0);

        rd_pend = 0;
        drive_dir();
        flush_empty_i = 1'b1;
        @(negedge clk);
        chk("idle_outputs_after_done", all_outs(), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_dir(input bit clean_only);
        for (int s = 0; s < SETS; s++) begin
            mv[s] = WAYS'($urandom);
            md[s] = clean_only ? '0 : WAYS'($urandom);
            for (int w = 0; w < WAYS; w++) mt[s][w] = TW'($urandom);
        end
    endtask

    initial begin
        int  dr, k, ndone, nbusy;
        bit  found;

        rst_ni = 1'b0;
        sweep_req_i = 1'b0; sweep_inval_i = 1'b0;
        flush_alloc_ready_i = 1'b1; flush_empty_i = 1'b1;
        rd_pend = 0; rd_set = '0;
        drive_dir();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Clean cache: only reads, done 3*SETS+2 cycles after acceptance.
        fill_dir(1);
        run_sweep(0, 0, 0, 0, dr);
        chk("clean_done_latency", dr, 14);
        chk("clean_no_alloc", obs_alloc.size(), 0);
        chk("clean_no_upd", obs_upd.size(), 0);

        // Set 2 ways 1 and 5 dirty.
        fill_dir(1);
        mv[2] = mv[2] | 8'h22; md[2] = 8'h22; mt[2][1] = 20'h11; mt[2][5] = 20'h22;
        run_sweep(0, 0, 0, 0, dr);
        chk("t2_alloc0_nline", obs_alloc.size() > 0 ? obs_alloc[0].nline : '0, {20'h11, 2'd2});
        chk("t2_alloc0_way", obs_alloc.size() > 0 ? obs_alloc[0].way : '0, 8'h02);
        chk("t2_alloc1_nline", obs_alloc.size() > 1 ? obs_alloc[1].nline : '0, {20'h22, 2'd2});
        chk("t2_alloc1_way", obs_alloc.size() > 1 ? obs_alloc[1].way : '0, 8'h20);
        chk("t2_upd1_inval", obs_upd.size() > 1 ? obs_upd[1].inv : 1'b1, 1'b0);

        // Same with the first allocation stalled for 3 cycles.
        fill_dir(1);
        mv[2] = mv[2] | 8'h22; md[2] = 8'h22; mt[2][1] = 20'h11; mt[2][5] = 20'h22;
        run_sweep(0, 2, 0, 0, dr);
        chk("t3_done_latency", dr, 14 + 2 + 3);
        chk("t3_upd_per_accept", obs_upd.size(), 2);

        // Invalidate mode, set 0 fully valid with way 0 dirty.
        for (int s = 0; s < SETS; s++) begin
            mv[s] = '0; md[s] = '0;
            for (int w = 0; w < WAYS; w++) mt[s][w] = TW'($urandom);
        end
        mv[0] = 8'hFF; md[0] = 8'h01;
        run_sweep(1, 0, 0, 0, dr);
        chk("t4_alloc_way", obs_alloc.size() > 0 ? obs_alloc[0].way : '0, 8'h01);
        chk("t4_alloc_inval", obs_alloc.size() > 0 ? obs_alloc[0].inv : 1'b0, 1'b1);
        chk("t4_upd0", obs_upd.size() > 0 ? obs_upd[0] : '0, {2'd0, 8'h01, 1'b1});
        chk("t4_upd1", obs_upd.size() > 1 ? obs_upd[1] : '0, {2'd0, 8'hFE, 1'b1});

        // Write-backs outstanding for 10 cycles after the last set.
        fill_dir(1);
        run_sweep(0, 0, 2, 0, dr);
        chk("t5_drain_latency", dr, 14 + 10);

        // Randomized sweeps with stalls, empty noise and stray requests.
        for (int n = 0; n < 8; n++) begin
            fill_dir(0);
            run_sweep(1'($urandom), 1, 1, 1, dr);
        end

        // Reset while an allocation is pending.
        for (int s = 0; s < SETS; s++) begin
            mv[s] = 8'hFF; md[s] = 8'hFF;
            for (int w = 0; w < WAYS; w++) mt[s][w] = TW'($urandom);
        end
        rd_pend = 0;
        sweep_req_i = 1'b1; sweep_inval_i = 1'b0;
        flush_alloc_ready_i = 1'b0; flush_empty_i = 1'b1;
        drive_dir();
        found = 0; k = 0;
        while (!found && k < 20) begin
            @(negedge clk);
            if (flush_alloc_o) begin
                found = 1;
            end else begin
                rd_pend = dir_read_o;
                rd_set  = dir_read_set_o;
                @(posedge clk);
                #1;
                sweep_req_i = 1'b0;
                drive_dir();
                k++;
            end
        end
        chk("rst_reached_alloc", found, 1'b1);
        rst_ni = 1'b0;
        sweep_req_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mid_alloc_outputs", all_outs(), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        flush_alloc_ready_i = 1'b1;
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ndone += int'(sweep_done_o);
            nbusy += int'(sweep_busy_o);
            @(posedge clk);
            #1;
        end
        chk("rst_no_done_pulse", ndone, 0);
        chk("rst_stays_idle", nbusy, 0);
        rd_pend = 0;
        run_sweep(0, 0, 0, 0, dr);
        chk("restart_done_latency", dr, 14 + 8*SETS);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
